button_switch_input_controller: RTL and testbench



---
 rtl/button_switch_input_controller_pkg.sv | 45 ++++
 rtl/button_switch_input_controller_debouncer.sv | 68 ++++++
 rtl/button_switch_input_controller.sv | 91 +++++++++
 tb/tb_button_switch_input_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_switch_input_controller_pkg.sv
// Shared types and constants for the button/switch input controller.
// Includes button bit ordering, bus structures and a small edge-detect helper.
package button_switch_input_controller_pkg;

  // Button bit positions within every 5-bit button vector.
  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_LEFT   = 4;

  localparam int NUM_BUTTONS  = 5;
  localparam int NUM_SWITCHES = 16;

  // 10 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef logic [NUM_BUTTONS-1:0]  button_mask_t;
  typedef button_mask_t            buttons_t;
  typedef logic [NUM_SWITCHES-1:0] switch_vec_t;

  // Fields the CPU reads from the input side.
  typedef struct packed {
    button_mask_t button_state;
    button_mask_t press_events;
    switch_vec_t  switch_state;
    logic         switch_changed;
    logic         event_pending;
  } peripheral_status_bus_t;

  // Fields the CPU writes to acknowledge events.
  typedef struct packed {
    button_mask_t press_clear;
    logic         switch_ack;
  } peripheral_control_bus_t;

  // Buttons whose debounced level is about to go 0->1: an accept on a
  // single-bit debouncer always flips the level, so the old level tells
  // the direction.
  function automatic button_mask_t rising_mask(input button_mask_t accept,
                                               input button_mask_t level);
    return accept & ~level;
  endfunction

endpackage

// File: rtl/button_switch_input_controller_debouncer.sv
// Synchroniser plus debounce for a WIDTH-bit group that is accepted as a whole.
// A new value is loaded into the stable register once the synchronised input
// has held one identical value, different from the stable one, for CYCLES
// consecutive cycles. accept_o is high in the cycle whose closing edge loads it.
module button_switch_input_controller_debouncer #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             accept_o
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             accept_s;

  // Decide whether the synchronised value has been held long enough to accept.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept_s = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (sync2_q != prev_q) begin
      // A fresh value counts as its own first cycle of holding.
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = sync2_q;
      accept_s = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchroniser, previous-value, counter and stable registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign accept_o = accept_s;

endmodule

// File: rtl/button_switch_input_controller.sv
// Conditions raw buttons and switches into debounced levels and sticky,
// CPU-acknowledged event flags. Buttons debounce per bit, switches as a vector.
module button_switch_input_controller
  import button_switch_input_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic         clock_100mhz,
  input  logic         reset,
  input  buttons_t     buttons,
  input  logic [15:0]  switches,
  input  button_mask_t press_clear,
  input  logic         switch_ack,
  output button_mask_t button_state,
  output button_mask_t press_events,
  output logic [15:0]  switch_state,
  output logic         switch_changed,
  output logic         event_pending
);

  peripheral_control_bus_t ctrl_bus_s;
  peripheral_status_bus_t  status_bus_s;

  button_mask_t btn_stable_s;
  button_mask_t btn_accept_s;
  switch_vec_t  sw_stable_s;
  logic         sw_accept_s;

  button_mask_t press_q;
  button_mask_t press_d;
  logic         changed_q;
  logic         changed_d;

  assign ctrl_bus_s.press_clear = press_clear;
  assign ctrl_bus_s.switch_ack  = switch_ack;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_switch_input_controller_debouncer #(
      .WIDTH  (1),
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
      .clk_i    (clock_100mhz),
      .rst_i    (reset),
      .raw_i    (buttons[g]),
      .stable_o (btn_stable_s[g]),
      .accept_o (btn_accept_s[g])
    );
  end

  button_switch_input_controller_debouncer #(
    .WIDTH  (NUM_SWITCHES),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk_i    (clock_100mhz),
    .rst_i    (reset),
    .raw_i    (switches),
    .stable_o (sw_stable_s),
    .accept_o (sw_accept_s)
  );

  // Sticky flags: a new event on the same edge as its clear wins, so none is lost.
  always_comb begin
    press_d   = (press_q & ~ctrl_bus_s.press_clear)
              | rising_mask(btn_accept_s, btn_stable_s);
    changed_d = sw_accept_s | (changed_q & ~ctrl_bus_s.switch_ack);
  end

  // Flag registers.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      press_q   <= 5'b00000;
      changed_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      changed_q <= changed_d;
    end
  end

  assign status_bus_s.button_state   = btn_stable_s;
  assign status_bus_s.press_events   = press_q;
  assign status_bus_s.switch_state   = sw_stable_s;
  assign status_bus_s.switch_changed = changed_q;
  assign status_bus_s.event_pending  = (|press_q) | changed_q;

  assign button_state   = status_bus_s.button_state;
  assign press_events   = status_bus_s.press_events;
  assign switch_state   = status_bus_s.switch_state;
  assign switch_changed = status_bus_s.switch_changed;
  assign event_pending  = status_bus_s.event_pending;

endmodule

// File: tb/tb_button_switch_input_controller.sv
// Directed bench for button_switch_input_controller with DEBOUNCE_CYCLES=4.
// A window-based reference model is checked every cycle; literal checks at key
// points pin the model to hand-computed values.
module tb_button_switch_input_controller;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic [4:0]  buttons;
  logic [15:0] switches;
  logic [4:0]  press_clear;
  logic        switch_ack;
  logic [4:0]  button_state;
  logic [4:0]  press_events;
  logic [15:0] switch_state;
  logic        switch_changed;
  logic        event_pending;

  int checks   = 0;
  int failures = 0;

  button_switch_input_controller #(.DEBOUNCE_CYCLES(N)) dut (
    .clock_100mhz   (clk),
    .reset          (reset),
    .buttons        (buttons),
    .switches       (switches),
    .press_clear    (press_clear),
    .switch_ack     (switch_ack),
    .button_state   (button_state),
    .press_events   (press_events),
    .switch_state   (switch_state),
    .switch_changed (switch_changed),
    .event_pending  (event_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchroniser modelled as a 2-deep delay line; an input value is accepted
  // once the last N synchronised samples since reset all show it.
  logic [4:0]  m_b1, m_b2;
  logic [15:0] m_s1, m_s2;
  logic [4:0]  hb [N];
  logic [15:0] hs [N];
  int          hlen;
  logic [4:0]  e_btn, e_press;
  logic [15:0] e_sw;
  logic        e_chg;

  task automatic model_step();
    logic [4:0] nb;
    logic       all_b;
    logic       all_s;
    if (reset) begin
      m_b1 = 5'd0; m_b2 = 5'd0; m_s1 = 16'd0; m_s2 = 16'd0;
      hlen = 0;
      e_btn = 5'd0; e_press = 5'd0; e_sw = 16'd0; e_chg = 1'b0;
    end else begin
      for (int j = N - 1; j > 0; j--) begin
        hb[j] = hb[j-1];
        hs[j] = hs[j-1];
      end
      hb[0] = m_b2;
      hs[0] = m_s2;
      if (hlen < N) hlen++;
      nb = e_btn;
      for (int i = 0; i < 5; i++) begin
        all_b = (hlen >= N);
        for (int j = 0; j < N; j++) begin
          if (hb[j][i] == e_btn[i]) all_b = 1'b0;
        end
        if (all_b) nb[i] = hb[0][i];
      end
      e_press = (e_press & ~press_clear) | (nb & ~e_btn);
      e_btn   = nb;
      all_s = (hlen >= N) && (hs[0] != e_sw);
      for (int j = 0; j < N; j++) begin
        if (hs[j] != hs[0]) all_s = 1'b0;
      end
      e_chg = all_s | (e_chg & ~switch_ack);
      if (all_s) e_sw = hs[0];
      m_b2 = m_b1; m_b1 = buttons;
      m_s2 = m_s1; m_s1 = switches;
    end
  endtask

  // Compare process: advance model on each edge, check DUT 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("m_button_state",   {11'd0, button_state}, {11'd0, e_btn});
      chk("m_press_events",   {11'd0, press_events}, {11'd0, e_press});
      chk("m_switch_state",   switch_state,          e_sw);
      chk("m_switch_changed", {15'd0, switch_changed}, {15'd0, e_chg});
      chk("m_event_pending",  {15'd0, event_pending},  {15'd0, (|e_press) | e_chg});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; buttons = 5'b00000; switches = 16'h00A5;
    press_clear = 5'b00000; switch_ack = 1'b0;
    step(3);
    chk("rst_btn",  {11'd0, button_state}, 16'h0000);
    chk("rst_prs",  {11'd0, press_events}, 16'h0000);
    chk("rst_sw",   switch_state, 16'h0000);
    chk("rst_chg",  {15'd0, switch_changed}, 16'h0000);
    chk("rst_pend", {15'd0, event_pending}, 16'h0000);
    reset = 1'b0;
    step(5);
    chk("init_sw_e5",  switch_state, 16'h0000);
    chk("init_chg_e5", {15'd0, switch_changed}, 16'h0000);
    step(1);
    chk("init_sw_e6",   switch_state, 16'h00A5);
    chk("init_chg_e6",  {15'd0, switch_changed}, 16'h0001);
    chk("init_pend_e6", {15'd0, event_pending}, 16'h0001);
    switch_ack = 1'b1; step(1); switch_ack = 1'b0;
    chk("ack_chg",  {15'd0, switch_changed}, 16'h0000);
    chk("ack_pend", {15'd0, event_pending}, 16'h0000);

    // Up pressed and held.
    buttons = 5'b00010;
    step(5);
    chk("up_btn_e5", {11'd0, button_state}, 16'h0000);
    step(1);
    chk("up_btn_e6",  {11'd0, button_state}, 16'h0002);
    chk("up_prs_e6",  {11'd0, press_events}, 16'h0002);
    chk("up_pend_e6", {15'd0, event_pending}, 16'h0001);
    step(8);
    chk("up_held_prs", {11'd0, press_events}, 16'h0002);

    // Left accepted on the same edge that up is cleared.
    buttons = 5'b10010;
    step(5);
    press_clear = 5'b00010; step(1); press_clear = 5'b00000;
    chk("left_clr_prs", {11'd0, press_events}, 16'h0010);
    chk("left_clr_btn", {11'd0, button_state}, 16'h0012);

    // Center bounce: high for 3 cycles only.
    buttons = 5'b10011; step(3); buttons = 5'b10010;
    step(8);
    chk("bounce_btn", {11'd0, button_state}, 16'h0012);
    chk("bounce_prs", {11'd0, press_events}, 16'h0010);

    press_clear = 5'b10000; step(1); press_clear = 5'b00000;
    chk("clr_left_prs",  {11'd0, press_events}, 16'h0000);
    chk("clr_left_pend", {15'd0, event_pending}, 16'h0000);

    // Down accepted on the same edge its own clear arrives: set wins.
    buttons = 5'b11010;
    step(5);
    press_clear = 5'b01000; step(1); press_clear = 5'b00000;
    chk("setwins_prs", {11'd0, press_events}, 16'h0008);
    press_clear = 5'b01000; step(1); press_clear = 5'b00000;
    chk("down_clr_prs", {11'd0, press_events}, 16'h0000);

    // Switch update, then a second update colliding with ack.
    switches = 16'h1234; step(6);
    chk("sw1234_sw",  switch_state, 16'h1234);
    chk("sw1234_chg", {15'd0, switch_changed}, 16'h0001);
    switches = 16'h0F00; step(5);
    switch_ack = 1'b1; step(1); switch_ack = 1'b0;
    chk("sw_ackwin_sw",  switch_state, 16'h0F00);
    chk("sw_ackwin_chg", {15'd0, switch_changed}, 16'h0001);
    switch_ack = 1'b1; step(1); switch_ack = 1'b0;
    chk("sw_ack2_chg", {15'd0, switch_changed}, 16'h0000);

    // Short switch glitch is rejected.
    switches = 16'h0F01; step(2); switches = 16'h0F00; step(8);
    chk("sw_glitch_sw",  switch_state, 16'h0F00);
    chk("sw_glitch_chg", {15'd0, switch_changed}, 16'h0000);

    // Vector change mid-debounce restarts the count.
    switches = 16'hAAAA; step(2); switches = 16'h5555;
    step(5);
    chk("sw_restart_e5", switch_state, 16'h0F00);
    step(1);
    chk("sw_restart_e6", switch_state, 16'h5555);
    switch_ack = 1'b1; step(1); switch_ack = 1'b0;

    // Release sets no event.
    buttons = 5'b00000; step(6);
    chk("release_btn", {11'd0, button_state}, 16'h0000);
    chk("release_prs", {11'd0, press_events}, 16'h0000);

    // Reset two cycles into a right-button debounce.
    buttons = 5'b00100; step(2);
    reset = 1'b1; step(2);
    chk("midrst_btn", {11'd0, button_state}, 16'h0000);
    chk("midrst_sw",  switch_state, 16'h0000);
    reset = 1'b0;
    step(5);
    chk("midrst_btn_e5", {11'd0, button_state}, 16'h0000);
    step(1);
    chk("midrst_btn_e6", {11'd0, button_state}, 16'h0004);
    chk("midrst_prs_e6", {11'd0, press_events}, 16'h0004);
    chk("midrst_sw_e6",  switch_state, 16'h5555);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
